// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - dmem valid/ready request/response bundle
interface dmem_responder_if;
    logic        dmem_valid_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic [3:0]  dmem_we_i;
    logic        dmem_ready_o;
    logic [31:0] dmem_rdata_o;
    logic        dmem_err_o;

    modport master (
        output dmem_valid_i, dmem_addr_i, dmem_wdata_i, dmem_we_i,
        input  dmem_ready_o, dmem_rdata_o, dmem_err_o
    );

    modport slave (
        input  dmem_valid_i, dmem_addr_i, dmem_wdata_i, dmem_we_i,
        output dmem_ready_o, dmem_rdata_o, dmem_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data RAM responder with fixed wait states and byte-lane writes
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [29:0] word_q;
    logic [31:0] wdata_q;
    logic [3:0]  we_q;
    logic [31:0] rdata_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic [29:0] rd_word;
    logic        rd_in_range;
    logic        q_in_range;

    assign accept = (state == ST_IDLE) && bus.dmem_valid_i;

    // With zero wait states the read happens on the accept edge, before word_q is loaded
    assign rd_word     = (state == ST_IDLE) ? bus.dmem_addr_i[31:2] : word_q;
    assign rd_in_range = {2'b00, rd_word} < 32'(DEPTH_WORDS);
    assign q_in_range  = {2'b00, word_q} < 32'(DEPTH_WORDS);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.dmem_valid_i) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if ((state_nxt == ST_RESP) && (state != ST_RESP)) begin
                rdata_q <= rd_in_range ? mem[rd_word[IDX_W-1:0]] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            word_q  <= bus.dmem_addr_i[31:2];
            wdata_q <= bus.dmem_wdata_i;
            we_q    <= bus.dmem_we_i;
        end
    end

    // RAM is deliberately left out of reset; a reset during RESP suppresses the write
    always_ff @(posedge clk) begin
        if ((state == ST_RESP) && !rst && q_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (we_q[k]) begin
                    mem[word_q[IDX_W-1:0]][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign bus.dmem_ready_o = (state == ST_RESP) && !rst;
    assign bus.dmem_err_o   = bus.dmem_ready_o && !q_in_range;
    assign bus.dmem_rdata_o = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if if_a ();
    dmem_responder_if if_0 ();
    dmem_responder_if if_f ();

    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  we = 4'h0;
    logic        vld [3];
    int          sel = 0;

    assign if_a.dmem_valid_i = vld[0];
    assign if_0.dmem_valid_i = vld[1];
    assign if_f.dmem_valid_i = vld[2];
    assign if_a.dmem_addr_i = addr;  assign if_a.dmem_wdata_i = wdata;  assign if_a.dmem_we_i = we;
    assign if_0.dmem_addr_i = addr;  assign if_0.dmem_wdata_i = wdata;  assign if_0.dmem_we_i = we;
    assign if_f.dmem_addr_i = addr;  assign if_f.dmem_wdata_i = wdata;  assign if_f.dmem_we_i = we;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1))  u_dut   (.clk(clk), .rst(rst), .bus(if_a.slave));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0))  u_dut0  (.clk(clk), .rst(rst), .bus(if_0.slave));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(15)) u_dut15 (.clk(clk), .rst(rst), .bus(if_f.slave));

    logic        m_ready;
    logic [31:0] m_rdata;
    logic        m_err;
    always_comb begin
        m_ready = if_a.dmem_ready_o;
        m_rdata = if_a.dmem_rdata_o;
        m_err   = if_a.dmem_err_o;
        if (sel == 1) begin
            m_ready = if_0.dmem_ready_o; m_rdata = if_0.dmem_rdata_o; m_err = if_0.dmem_err_o;
        end else if (sel == 2) begin
            m_ready = if_f.dmem_ready_o; m_rdata = if_f.dmem_rdata_o; m_err = if_f.dmem_err_o;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          chk;
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Scoreboard: every ready pulse on the selected DUT consumes one expected response
    always @(negedge clk) begin
        if (m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_err", {31'b0, m_err}, {31'b0, e.err});
                if (e.chk) check("resp_rdata", m_rdata, e.rd);
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                          input bit chk, input logic [31:0] rd, input logic er, input int exp_lat);
        int lat;
        exp_t e;
        e.chk = chk; e.rd = rd; e.err = er;
        sb.push_back(e);
        addr = a; wdata = d; we = w; vld[sel] = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            if (m_ready) break;
            lat++;
            if (lat > 40) begin
                check("req_timeout", 32'd1, 32'd0);
                break;
            end
        end
        vld[sel] = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    task automatic hold_test(input logic [31:0] a, input logic [31:0] rd, input int period);
        int t [4];
        int n;
        int guard;
        exp_t e;
        e.chk = 1'b1; e.rd = rd; e.err = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(e);
        addr = a; we = 4'h0; vld[sel] = 1'b1;
        n = 0; guard = 0;
        while (n < 4 && guard < 80) begin
            @(negedge clk);
            guard++;
            if (m_ready) begin
                t[n] = cyc;
                n++;
            end
        end
        vld[sel] = 1'b0;
        check("hold_pulses", 32'(n), 32'd4);
        for (int i = 1; i < n; i++) check("hold_period", 32'(t[i] - t[i-1]), 32'(period));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        bit          chk;
        logic [31:0] rd;
        logic        er;
    } vec_t;
    vec_t vecs [15];

    initial begin
        logic any_ready, any_err;
        logic [31:0] any_rdata;
        int pulses;

        vecs[0]  = '{32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{32'h0000_0010, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{32'h0000_0020, 32'h11223344, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{32'h0000_0020, 32'h00AA0000, 4'h4, 1'b1, 32'h11223344, 1'b0};
        vecs[4]  = '{32'h0000_0020, 32'h0,        4'h0, 1'b1, 32'h11AA3344, 1'b0};
        vecs[5]  = '{32'h0000_0020, 32'hBBBB0000, 4'hC, 1'b1, 32'h11AA3344, 1'b0};
        vecs[6]  = '{32'h0000_0020, 32'h0,        4'h0, 1'b1, 32'hBBBB3344, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'h0BADF00D, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[8]  = '{32'h0000_0FFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{32'h0000_1000, 32'h12345678, 4'hF, 1'b1, 32'h0,        1'b1};
        vecs[10] = '{32'h0000_0000, 32'h0,        4'h0, 1'b1, 32'h0BADF00D, 1'b0};
        vecs[11] = '{32'h0000_0FFC, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 1'b0};
        vecs[12] = '{32'h0000_2000, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        vecs[13] = '{32'h0000_0013, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[14] = '{32'h0000_0030, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0};

        vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        any_ready = 1'b0; any_err = 1'b0; any_rdata = 32'h0;
        repeat (20) begin
            @(negedge clk);
            any_ready |= if_a.dmem_ready_o | if_0.dmem_ready_o | if_f.dmem_ready_o;
            any_err   |= if_a.dmem_err_o   | if_0.dmem_err_o   | if_f.dmem_err_o;
            any_rdata |= if_a.dmem_rdata_o | if_0.dmem_rdata_o | if_f.dmem_rdata_o;
        end
        check("reset_ready", {31'b0, any_ready}, 32'd0);
        check("reset_err",   {31'b0, any_err},   32'd0);
        check("reset_rdata", any_rdata,          32'd0);
        @(posedge clk); #1;

        sel = 0;
        for (int i = 0; i < 15; i++)
            do_req(vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].chk, vecs[i].rd, vecs[i].er, 2);

        hold_test(32'h10, 32'hDEADBEEF, 3);

        // Valid dropped and address changed after accept: response uses the latched request
        begin
            exp_t e;
            e.chk = 1'b1; e.rd = 32'hBBBB3344; e.err = 1'b0;
            sb.push_back(e);
        end
        addr = 32'h20; we = 4'h0; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0; addr = 32'h10;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_ready) pulses++;
        end
        check("drop_valid_pulses", 32'(pulses), 32'd1);
        @(posedge clk); #1;

        // Reset lands on the RESP cycle of a write to 0x30
        addr = 32'h30; wdata = 32'hFFFF_FFFF; we = 4'hF; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_resp_ready", {31'b0, if_a.dmem_ready_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_resp_rdata", if_a.dmem_rdata_o, 32'd0);
        do_req(32'h30, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 2);

        sel = 1;
        do_req(32'h44, 32'h5A5A_A5A5, 4'hF, 1'b0, 32'h0, 1'b0, 1);
        do_req(32'h44, 32'h0, 4'h0, 1'b1, 32'h5A5A_A5A5, 1'b0, 1);
        hold_test(32'h44, 32'h5A5A_A5A5, 2);

        sel = 2;
        do_req(32'h48, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0, 1'b0, 16);
        do_req(32'h48, 32'h0, 4'h0, 1'b1, 32'h1357_9BDF, 1'b0, 16);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
